// File: rtl/fib_result_bcd.sv
// Iterative double-dabble binary-to-BCD converter for the Fibonacci result.
// One bit per clock, valid/ready on both sides, one conversion in flight.
module fib_result_bcd #(
   parameter int WIDTH  = 16,
   parameter int DIGITS = 5,
   parameter int NDW    = 3
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [WIDTH-1:0]      bin,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [4*DIGITS-1:0]   bcd,
   output logic [NDW-1:0]        ndigits
);

   localparam int CW = $clog2(WIDTH + 1);

   typedef enum logic [1:0] {
      IDLE,
      SHIFT,
      DONE
   } state_t;

   state_t              state;
   state_t              state_nxt;
   logic [WIDTH-1:0]    bin_q;
   logic [WIDTH-1:0]    bin_sh;
   logic [4*DIGITS-1:0] acc_q;
   logic [4*DIGITS-1:0] acc_adj;
   logic [4*DIGITS-1:0] acc_sh;
   logic [CW-1:0]       cnt_q;
   logic [NDW-1:0]      nd_calc;
   logic                last_shift;

   assign last_shift = (state == SHIFT) && (cnt_q == CW'(1));

   // Per-nibble +3 correction, then one shift of the combined register
   always_comb begin
      acc_adj = acc_q;
      for (int i = 0; i < DIGITS; i++) begin
         if (acc_q[4*i +: 4] >= 4'd5)
            acc_adj[4*i +: 4] = acc_q[4*i +: 4] + 4'd3;
      end
      {acc_sh, bin_sh} = {acc_adj, bin_q} << 1;
   end

   always_comb begin
      nd_calc = NDW'(1);
      for (int i = 0; i < DIGITS; i++) begin
         if (acc_sh[4*i +: 4] != 4'd0)
            nd_calc = NDW'(i + 1);
      end
   end

   always_comb begin
      state_nxt = state;
      in_ready  = 1'b0;
      out_valid = 1'b0;
      case (state)
         IDLE: begin
            in_ready = ~rst;
            if (in_valid)
               state_nxt = SHIFT;
         end
         SHIFT: begin
            if (cnt_q == CW'(1))
               state_nxt = DONE;
         end
         DONE: begin
            out_valid = 1'b1;
            if (out_ready)
               state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= IDLE;
         bin_q   <= '0;
         acc_q   <= '0;
         cnt_q   <= '0;
         bcd     <= '0;
         ndigits <= NDW'(1);
      end else begin
         state <= state_nxt;
         if (state == IDLE && in_valid) begin
            bin_q <= bin;
            acc_q <= '0;
            cnt_q <= CW'(WIDTH);
         end
         if (state == SHIFT) begin
            bin_q <= bin_sh;
            acc_q <= acc_sh;
            cnt_q <= cnt_q - CW'(1);
         end
         // Output register only ever sees the finished conversion
         if (last_shift) begin
            bcd     <= acc_sh;
            ndigits <= nd_calc;
         end
      end
   end

endmodule

// File: tb/tb_fib_result_bcd.sv
// Self-checking bench for fib_result_bcd against a decimal-arithmetic model.
// Directed corner cases plus randomized conversions with random back-pressure.
module tb_fib_result_bcd;

   logic        clk;
   logic        rst;
   logic        in_valid;
   logic        in_ready;
   logic [15:0] bin;
   logic        out_valid;
   logic        out_ready;
   logic [19:0] bcd;
   logic [2:0]  ndigits;

   int vectors = 0;
   int errors  = 0;

   fib_result_bcd #(.WIDTH(16), .DIGITS(5), .NDW(3)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .bin       (bin),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .bcd       (bcd),
      .ndigits   (ndigits)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [19:0] ref_bcd(input int unsigned v);
      logic [19:0] r;
      r = '0;
      for (int d = 0; d < 5; d++) begin
         r[4*d +: 4] = 4'(v % 10);
         v = v / 10;
      end
      return r;
   endfunction

   function automatic logic [2:0] ref_nd(input int unsigned v);
      int n;
      n = 1;
      v = v / 10;
      while (v != 0) begin
         n++;
         v = v / 10;
      end
      return 3'(n);
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Accepts v (caller has checked in_ready) and returns edges until out_valid, -1 on timeout
   task automatic run_conv(input logic [15:0] v, output int lat);
      in_valid = 1'b1;
      bin      = v;
      tick();
      in_valid = 1'b0;
      lat = -1;
      for (int k = 1; k <= 40; k++) begin
         tick();
         if (out_valid) begin
            lat = k;
            break;
         end
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      in_valid = 1'b0;
      out_ready = 1'b0;
      bin = '0;
      tick();
      tick();
      vectors++;
      if (in_ready !== 1'b0 || out_valid !== 1'b0 || bcd !== 20'h0 || ndigits !== 3'd1) begin
         errors++;
         $display("FAIL reset: in_ready=%b out_valid=%b bcd=%h nd=%0d, want 0 0 00000 1",
                  in_ready, out_valid, bcd, ndigits);
      end
      rst = 1'b0;
      #1;
      vectors++;
      if (in_ready !== 1'b1) begin
         errors++;
         $display("FAIL reset_release: in_ready=%b want 1", in_ready);
      end
   endtask

   task automatic test_value(input logic [15:0] v, input string name);
      int lat;
      run_conv(v, lat);
      vectors++;
      if (lat !== 16) begin
         errors++;
         $display("FAIL %s latency: got %0d want 16", name, lat);
      end
      vectors++;
      if (bcd !== ref_bcd(v) || ndigits !== ref_nd(v)) begin
         errors++;
         $display("FAIL %s result: bcd=%h nd=%0d want %h %0d",
                  name, bcd, ndigits, ref_bcd(v), ref_nd(v));
      end
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      vectors++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
         errors++;
         $display("FAIL %s handoff: out_valid=%b in_ready=%b want 0 1",
                  name, out_valid, in_ready);
      end
   endtask

   task automatic test_f17_stream();
      int lat;
      out_ready = 1'b1;
      run_conv(16'd1597, lat);
      vectors++;
      if (lat !== 16 || bcd !== 20'h01597 || ndigits !== 3'd4) begin
         errors++;
         $display("FAIL f17: lat=%0d bcd=%h nd=%0d want 16 01597 4", lat, bcd, ndigits);
      end
      tick();
      out_ready = 1'b0;
      vectors++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
         errors++;
         $display("FAIL f17_pulse: out_valid=%b in_ready=%b want 0 1", out_valid, in_ready);
      end
   endtask

   task automatic test_hold();
      int lat;
      int bad;
      run_conv(16'd610, lat);
      bad = 0;
      for (int k = 0; k < 10; k++) begin
         if (out_valid !== 1'b1 || in_ready !== 1'b0 || bcd !== 20'h00610 || ndigits !== 3'd3)
            bad++;
         tick();
      end
      vectors++;
      if (lat !== 16 || bad != 0) begin
         errors++;
         $display("FAIL hold: lat=%0d unstable_cycles=%0d want 16 0", lat, bad);
      end
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      vectors++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
         errors++;
         $display("FAIL hold_release: out_valid=%b in_ready=%b want 0 1", out_valid, in_ready);
      end
   endtask

   task automatic test_busy_drop();
      int lat;
      int busy_ready;
      in_valid = 1'b1;
      bin = 16'd233;
      tick();
      bin = 16'd9999;
      lat = -1;
      busy_ready = 0;
      for (int k = 1; k <= 40; k++) begin
         if (in_ready) busy_ready++;
         tick();
         if (out_valid) begin
            lat = k;
            break;
         end
      end
      in_valid = 1'b0;
      vectors++;
      if (lat !== 16 || bcd !== 20'h00233 || ndigits !== 3'd3 || busy_ready != 0) begin
         errors++;
         $display("FAIL busy_drop: lat=%0d bcd=%h nd=%0d busy_ready=%0d want 16 00233 3 0",
                  lat, bcd, ndigits, busy_ready);
      end
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      tick();
      vectors++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
         errors++;
         $display("FAIL busy_idle: out_valid=%b in_ready=%b want 0 1", out_valid, in_ready);
      end
   endtask

   task automatic test_rst_mid();
      int seen;
      in_valid = 1'b1;
      bin = 16'd4181;
      tick();
      in_valid = 1'b0;
      for (int k = 0; k < 7; k++) tick();
      rst = 1'b1;
      #1;
      vectors++;
      if (in_ready !== 1'b0) begin
         errors++;
         $display("FAIL rst_hold: in_ready=%b want 0", in_ready);
      end
      tick();
      rst = 1'b0;
      #1;
      vectors++;
      if (out_valid !== 1'b0 || bcd !== 20'h0 || ndigits !== 3'd1 || in_ready !== 1'b1) begin
         errors++;
         $display("FAIL rst_mid: out_valid=%b bcd=%h nd=%0d in_ready=%b want 0 00000 1 1",
                  out_valid, bcd, ndigits, in_ready);
      end
      seen = 0;
      for (int k = 0; k < 20; k++) begin
         tick();
         if (out_valid) seen++;
      end
      vectors++;
      if (seen != 0) begin
         errors++;
         $display("FAIL rst_discard: out_valid cycles=%0d want 0", seen);
      end
      test_value(16'd89, "after_rst");
   endtask

   task automatic test_random();
      logic [15:0] v;
      logic [19:0] held;
      int lat;
      int bad;
      for (int n = 0; n < 25; n++) begin
         v = 16'($urandom_range(0, 65535));
         if (n % 5 == 0) v = 16'($urandom_range(0, 99));
         vectors++;
         if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL rand_ready[%0d]: in_ready=%b want 1", n, in_ready);
         end
         out_ready = $urandom_range(0, 1) == 1 ? 1'b1 : 1'b0;
         run_conv(v, lat);
         out_ready = 1'b0;
         vectors++;
         if (lat !== 16 || bcd !== ref_bcd(v) || ndigits !== ref_nd(v)) begin
            errors++;
            $display("FAIL rand[%0d] bin=%0d: lat=%0d bcd=%h nd=%0d want 16 %h %0d",
                     n, v, lat, bcd, ndigits, ref_bcd(v), ref_nd(v));
         end
         held = bcd;
         bad = 0;
         for (int k = $urandom_range(0, 3); k > 0; k--) begin
            tick();
            if (out_valid !== 1'b1 || bcd !== held) bad++;
         end
         out_ready = 1'b1;
         tick();
         out_ready = 1'b0;
         vectors++;
         if (bad != 0 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL rand_hold[%0d]: unstable=%0d out_valid=%b want 0 0", n, bad, out_valid);
         end
         if ($urandom_range(0, 1) == 1) tick();
      end
   endtask

   initial begin
      test_reset();
      test_value(16'd0, "zero");
      test_value(16'hFFFF, "max");
      test_f17_stream();
      test_hold();
      test_busy_drop();
      test_rst_mid();
      test_value(16'd9, "one_digit");
      test_value(16'd10000, "five_digit");
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
      $finish;
   end

endmodule
